// File: rtl/nn_wb_bridge.sv
// Wishbone slave front end for the NN core: a CPU-fed sample FIFO streamed over
// valid/ready, plus a single-entry result holding register with a maskable interrupt.
module nn_wb_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DATA_W    = 16,
    parameter int          RES_W     = 16,
    parameter int          DEPTH     = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              in_valid_o,
    input  logic              in_ready_i,
    output logic [DATA_W-1:0] in_data_o,
    output logic              in_last_o,
    input  logic              res_valid_i,
    output logic              res_ready_o,
    input  logic [RES_W-1:0]  res_data_i,
    output logic              irq_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam int            CW       = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd1;
    localparam logic [2:0] OFF_PUSH   = 3'd2;
    localparam logic [2:0] OFF_RESULT = 3'd3;
    localparam logic [2:0] OFF_IRQ    = 3'd4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } bus_state_t;

    bus_state_t r_state;
    bus_state_t w_state_nxt;

    logic        w_hit;
    logic        w_req;
    logic        w_wr;
    logic        w_rd;
    logic [2:0]  w_off;
    logic [31:0] w_rdata;
    logic [31:0] r_rdata;

    logic [DATA_W:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_empty;
    logic            w_full;
    logic            w_push_req;
    logic            w_push;
    logic            w_pop;
    logic            w_flush;
    logic [DATA_W:0] w_entry;
    logic [DATA_W:0] w_head;

    logic             r_irq_en;
    logic             r_irq_flag;
    logic             r_overflow;
    logic             r_res_pending;
    logic [RES_W-1:0] r_res_data;
    logic             w_res_cap;
    logic             w_res_rd;
    logic             w_irq_clr;
    logic             w_ctrl_wr;
    logic             w_unused;

    // Byte lanes, sub-word address bits and the upper window offsets carry no meaning here.
    assign w_unused = ^{wbs_sel_i, wbs_adr_i[7:5], wbs_adr_i[1:0], wbs_dat_i};

    // ------------------------------------------------------------------
    // Bus FSM: a request is performed on the IDLE edge, acked in the next cycle
    // ------------------------------------------------------------------
    assign w_off = wbs_adr_i[4:2];
    assign w_hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    w_state_nxt = S_ACK;
                    w_req       = 1'b1;
                end
            end
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= S_IDLE;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rdata <= w_rd ? w_rdata : '0;
        end
    end

    assign w_wr      = w_req & wbs_we_i;
    assign w_rd      = w_req & ~wbs_we_i;
    assign wbs_ack_o = (r_state == S_ACK);
    assign wbs_dat_o = r_rdata;

    // ------------------------------------------------------------------
    // Register decode
    // ------------------------------------------------------------------
    assign w_ctrl_wr  = w_wr & (w_off == OFF_CTRL);
    assign w_flush    = w_ctrl_wr & wbs_dat_i[1];
    assign w_push_req = w_wr & (w_off == OFF_PUSH);
    assign w_irq_clr  = w_wr & (w_off == OFF_IRQ) & wbs_dat_i[0];
    assign w_res_rd   = w_rd & (w_off == OFF_RESULT);

    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_CTRL: w_rdata[0] = r_irq_en;
            OFF_STATUS: begin
                w_rdata[0]      = w_empty;
                w_rdata[1]      = w_full;
                w_rdata[2]      = r_res_pending;
                w_rdata[3]      = r_overflow;
                w_rdata[8 +: CW] = r_count;
            end
            OFF_RESULT: begin
                w_rdata[RES_W-1:0] = r_res_data;
                w_rdata[31]        = r_res_pending;
            end
            OFF_IRQ:  w_rdata[0] = r_irq_flag;
            default:  w_rdata = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Sample FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    // Fullness is judged before any same-cycle pop, so a push at full is always dropped.
    assign w_push  = w_push_req & ~w_full;
    assign w_pop   = ~w_empty & in_ready_i;
    assign w_entry = {wbs_dat_i[16], wbs_dat_i[DATA_W-1:0]};

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (w_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_req && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; entries are only observed through the count and the head is gated when empty.
    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign in_valid_o = ~w_empty;
    assign in_data_o  = w_empty ? '0 : w_head[DATA_W-1:0];
    assign in_last_o  = ~w_empty & w_head[DATA_W];

    // ------------------------------------------------------------------
    // Result holding register and interrupt
    // ------------------------------------------------------------------
    assign res_ready_o = ~r_res_pending;
    assign w_res_cap   = res_valid_i & ~r_res_pending;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_res_pending <= 1'b0;
            r_res_data    <= '0;
            r_irq_flag    <= 1'b0;
            r_irq_en      <= 1'b0;
        end else begin
            if (w_res_cap) begin
                r_res_data    <= res_data_i;
                r_res_pending <= 1'b1;
            end else if (w_res_rd) begin
                r_res_pending <= 1'b0;
            end
            // A capture in the same cycle as a W1C keeps the flag set.
            if (w_res_cap) begin
                r_irq_flag <= 1'b1;
            end else if (w_irq_clr) begin
                r_irq_flag <= 1'b0;
            end
            if (w_ctrl_wr) begin
                r_irq_en <= wbs_dat_i[0];
            end
        end
    end

    assign irq_o = r_irq_en & r_irq_flag;

endmodule
